hsi_encoder: RTL and testbench

Parallel-to-serial line encoder for the HSI link. It is the transmit-side counterpart that drives the serial line consumed by the HSI decoder. The block accepts bytes over a valid/ready handshake and emits frames on a single idle-high line, each bit held for BIT_LEN clocks. A frame is: start bit, 8 data bits, odd-parity bit, stop bit(s). Setting msg_last on a byte appends an idle gap after that frame, marking the end of the message.

---
 rtl/hsi_encoder.sv | 133 +++++++++++++
 tb/tb_hsi_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hsi_encoder.sv
// hsi_encoder: byte-to-serial HSI line encoder with odd parity, stop bits and message gaps
module hsi_encoder #(
    parameter int BIT_LEN  = 8,
    parameter int ML_FST   = 0,
    parameter int STOP_LEN = 1,
    parameter int MSG_GAP  = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       msg_last,
    output logic       ready,
    output logic       q,
    output logic       busy,
    output logic       frame_done,
    output logic       msg_done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

    localparam logic [3:0] BC_END = 4'(BIT_LEN - 1);
    localparam logic [5:0] SC_END = 6'(STOP_LEN * BIT_LEN - 1);
    localparam logic [5:0] SC_PRE = 6'(STOP_LEN * BIT_LEN - 2);
    localparam logic [7:0] GC_END = 8'(MSG_GAP - 1);
    localparam logic [7:0] GC_PRE = 8'(MSG_GAP - 2);

    state_t     state_q;
    logic [3:0] bc_q, bc_d;
    logic [2:0] idx_q, idx_d;
    logic [5:0] sc_q;
    logic [7:0] gc_q;
    logic [7:0] data_q;
    logic       par_q, last_q, ready_q, q_q, busy_q, fd_q, md_q;
    logic       bit_end, bit_d;

    assign ready      = ready_q;
    assign q          = q_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign msg_done   = md_q;

    // Bit-clock wrap and the next data level to put on the line, honouring bit order
    always_comb begin
        bit_end = (bc_q == BC_END);
        bc_d    = bit_end ? 4'd0 : bc_q + 4'd1;
        idx_d   = (state_q == DATA) ? idx_q + 3'd1 : 3'd0;
        bit_d   = (ML_FST != 0) ? data_q[3'd7 - idx_d] : data_q[idx_d];
    end

    // Frame sequencer; all outputs are registered so the line only moves on clk edges
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            bc_q    <= '0;
            idx_q   <= '0;
            sc_q    <= '0;
            gc_q    <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            q_q     <= 1'b1;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
            md_q    <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            md_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid && ready_q) begin
                        state_q <= START;
                        data_q  <= data;
                        par_q   <= ~^data;
                        last_q  <= msg_last;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        q_q     <= 1'b0;
                        bc_q    <= '0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    bc_q <= bc_d;
                    if (bit_end) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        q_q     <= bit_d;
                    end
                end
                DATA: begin
                    bc_q <= bc_d;
                    if (bit_end && idx_q == 3'd7) begin
                        state_q <= PARITY;
                        q_q     <= par_q;
                    end else if (bit_end) begin
                        idx_q <= idx_d;
                        q_q   <= bit_d;
                    end
                end
                PARITY: begin
                    bc_q <= bc_d;
                    if (bit_end) begin
                        state_q <= STOP;
                        sc_q    <= '0;
                        q_q     <= 1'b1;
                    end
                end
                STOP: begin
                    sc_q <= sc_q + 6'd1;
                    fd_q <= (sc_q == SC_PRE);
                    if (sc_q == SC_END) begin
                        state_q <= last_q ? GAP : IDLE;
                        gc_q    <= '0;
                        busy_q  <= last_q;
                        ready_q <= ~last_q;
                    end
                end
                GAP: begin
                    gc_q <= gc_q + 8'd1;
                    md_q <= (gc_q == GC_PRE);
                    if (gc_q == GC_END) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hsi_encoder.sv
// tb_hsi_encoder: two encoder configurations checked cycle by cycle against a timeline model
module tb_hsi_encoder;
    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [7:0] data_v [2];
    logic [1:0] valid_v, last_v, ready_v, q_v, busy_v, fd_v, md_v;
    int total = 0;
    int bad = 0;
    int bl [2] = '{8, 2};
    int sl [2] = '{1, 4};
    int gp [2] = '{16, 4};
    int ml [2] = '{0, 1};

    always #5 clk = ~clk;

    hsi_encoder u0 (
        .clk(clk), .n_rst(n_rst), .data(data_v[0]), .valid(valid_v[0]), .msg_last(last_v[0]),
        .ready(ready_v[0]), .q(q_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]), .msg_done(md_v[0])
    );

    hsi_encoder #(.BIT_LEN(2), .ML_FST(1), .STOP_LEN(4), .MSG_GAP(4)) u1 (
        .clk(clk), .n_rst(n_rst), .data(data_v[1]), .valid(valid_v[1]), .msg_last(last_v[1]),
        .ready(ready_v[1]), .q(q_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]), .msg_done(md_v[1])
    );

    // Expected line level in clock k after accept: start, 8 data bits, parity, then high
    function automatic logic exp_q(input int u, input logic [7:0] b, input int k);
        int lvl;
        lvl = (k - 1) / bl[u];
        if (lvl == 0) return 1'b0;
        if (lvl <= 8) return (ml[u] != 0) ? b[8 - lvl] : b[lvl - 1];
        if (lvl == 9) return ~^b;
        return 1'b1;
    endfunction

    // Sends one byte and checks {q,busy,frame_done,msg_done,ready} every clock until ready returns
    task automatic send_frame(input int u, input logic [7:0] b, input logic last, input bit abuse);
        int fend;
        int tend;
        int w;
        logic [4:0] got, exp;
        fend = (10 + sl[u]) * bl[u];
        tend = fend + (last ? gp[u] : 0);
        w = 0;
        while (ready_v[u] !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (ready_v[u] !== 1'b1) begin
            bad++;
            $display("FAIL ready_wait u%0d: got %b want 1", u, ready_v[u]);
        end
        data_v[u] = b;
        last_v[u] = last;
        valid_v[u] = 1'b1;
        for (int k = 1; k <= tend + 1; k++) begin
            @(negedge clk);
            got = {q_v[u], busy_v[u], fd_v[u], md_v[u], ready_v[u]};
            exp = {exp_q(u, b, k), k <= tend, k == fend, last && k == tend, k > tend};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL frame u%0d byte=%h last=%b clk=%0d: got q,busy,fd,md,rdy=%b want %b",
                         u, b, last, k, got, exp);
            end
            if (abuse) begin
                valid_v[u] = 1'b1;
                data_v[u] = 8'($urandom);
                last_v[u] = 1'($urandom);
            end else begin
                valid_v[u] = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        valid_v = '0;
        last_v = '0;
        data_v[0] = '0;
        data_v[1] = '0;
        #2 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({q_v, busy_v, fd_v, md_v, ready_v} !== 10'b11_00_00_00_00) begin
            bad++;
            $display("FAIL reset_hold: got q=%b busy=%b fd=%b md=%b rdy=%b want 11 00 00 00 00",
                     q_v, busy_v, fd_v, md_v, ready_v);
        end
        n_rst = 1'b1;
        #1;
        total++;
        if (ready_v !== 2'b00) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 00", ready_v);
        end
        @(negedge clk);
        total++;
        if ({ready_v, q_v, busy_v} !== 6'b11_11_00) begin
            bad++;
            $display("FAIL reset_first_clock: got rdy=%b q=%b busy=%b want 11 11 00", ready_v, q_v, busy_v);
        end
    endtask

    task automatic test_lsb_first;
        send_frame(0, 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_msb_first;
        send_frame(1, 8'h80, 1'b0, 1'b0);
        send_frame(1, 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_parity;
        logic [7:0] pats [3] = '{8'h00, 8'h01, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            send_frame(0, pats[i], 1'b0, 1'b0);
            send_frame(1, pats[i], 1'b0, 1'b0);
        end
    endtask

    task automatic test_msg_end;
        send_frame(0, 8'h3C, 1'b1, 1'b0);
        send_frame(1, 8'h3C, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        send_frame(1, 8'h5A, 1'b1, 1'b0);
        send_frame(1, 8'hC3, 1'b0, 1'b0);
        send_frame(1, 8'h0F, 1'b0, 1'b0);
        send_frame(0, 8'h96, 1'b0, 1'b0);
        send_frame(0, 8'h69, 1'b1, 1'b0);
    endtask

    task automatic test_handshake_abuse;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'hE7, 1'b0, 1'b1);
        send_frame(0, 8'h42, 1'b0, 1'b0);
        send_frame(1, 8'h77, 1'b1, 1'b1);
        send_frame(1, 8'h18, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            send_frame(i % 2, 8'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    // Reset dropped mid-DATA must force the line high at once and suppress every pulse
    task automatic test_reset_mid;
        bit pulsed;
        bit low_seen;
        int w;
        w = 0;
        while (ready_v[0] !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        data_v[0] = 8'h00;
        last_v[0] = 1'b1;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (3 * bl[0]) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        total++;
        if ({q_v[0], busy_v[0], ready_v[0]} !== 3'b100) begin
            bad++;
            $display("FAIL reset_mid_async: got q=%b busy=%b rdy=%b want 1 0 0", q_v[0], busy_v[0], ready_v[0]);
        end
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        pulsed = 1'b0;
        low_seen = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (fd_v[0] !== 1'b0 || md_v[0] !== 1'b0) pulsed = 1'b1;
            if (q_v[0] !== 1'b1) low_seen = 1'b1;
        end
        total++;
        if ({pulsed, low_seen} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_after: got pulsed=%b line_low=%b want 0 0", pulsed, low_seen);
        end
        total++;
        if ({ready_v[0], busy_v[0]} !== 2'b10) begin
            bad++;
            $display("FAIL reset_mid_ready: got rdy=%b busy=%b want 1 0", ready_v[0], busy_v[0]);
        end
        send_frame(0, 8'hB4, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_parity();
        test_msg_end();
        test_back_to_back();
        test_handshake_abuse();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
